alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational ALU datapath: add, subtract, multiply, divide, modulus, logic and shift/support ops behind a start/busy/done handshake.
- Operands are captured at start. The result register can feed back as operand A, so operations can be chained.
- Multiply and divide/modulus are iterative: one bit per clock.
- Sits between the operand/opcode source (control unit or testbench) and the result/flag consumers.

Parameters:
- WIDTH, 16, operand width in bits; result is 2*WIDTH bits. WIDTH >= 4, power of two.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- op  input  4  opcode, latched on accept
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- use_acc  input  1  on accept, A = result[WIDTH-1:0] instead of port a
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse when result/flags are updated
- result  output  2*WIDTH  result register
- ovf  output  1  signed overflow of last ADD/SUB
- dz  output  1  divide-by-zero on last DIV/MOD

Behaviour:
- Reset (async, rst_n=0): result=0, ovf=0, dz=0, busy=0, done=0, state=IDLE. Takes effect immediately, including mid-operation; the in-flight op is discarded.
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOD
  - 6 AND, 7 OR, 8 XOR, 9 NOT(A), A NAND, B NOR, C XNOR
  - D SHL, E SHR, F CLR
- States: IDLE, MUL, DIV.
  - Accept = rising edge with start=1 and state=IDLE. At accept, op/A/B are latched.
  - start while busy=1 is ignored; no queuing.
- Single-cycle ops (all except MUL/DIV/MOD, plus DIV/MOD with B=0):
  - result and flags are written at the accept edge.
  - done=1 for the following cycle; busy stays 0.
  - Back-to-back accepts on consecutive edges are allowed.
- ADD/SUB:
  - WIDTH-bit two's complement; SUB = A + ~B + 1.
  - result = sum sign-extended to 2*WIDTH.
  - ovf = carry into MSB XOR carry out of MSB.
  - dz is cleared.
- MUL:
  - Unsigned WIDTH x WIDTH -> 2*WIDTH, shift-add.
  - busy=1 from the accept edge until the result edge, with WIDTH iteration edges after accept.
  - Result is written, done pulses and busy falls at edge accept+WIDTH.
  - ovf=0, dz=0.
- DIV/MOD, B != 0:
  - Unsigned restoring division, WIDTH iterations, same timing as MUL.
  - DIV result = zero-extended quotient; MOD result = zero-extended remainder.
  - ovf=0, dz=0.
- DIV/MOD, B == 0: single cycle; result=0, dz=1, ovf=0; no FSM entry.
- Logic ops: bitwise on WIDTH bits, zero-extended to 2*WIDTH; ovf=0, dz=0.
- SHL/SHR:
  - Logical shift of A by B[log2(WIDTH)-1:0]; WIDTH-bit result, zero-extended.
  - B upper bits are ignored; shift by 0 returns A.
- NOP: result, ovf, dz held; done still pulses.
- CLR: result=0, ovf=0, dz=0; done pulses.
- Flag persistence: ovf and dz hold their value until the next op completes.
- use_acc: always uses the current result register (low half) as A, sampled at the accept edge. This includes the result written on that same edge by nothing else, since there is no concurrent write.
- done and the result write never occur in the same cycle as another accept for MUL/DIV/MOD.

Optional Feature:
- ALU_SAT_EN defined: ADD/SUB saturate on signed overflow.
  - Result = sign-extended 2^(WIDTH-1)-1 on positive overflow, -2^(WIDTH-1) on negative overflow.
  - ovf is still set to 1.
- ALU_SAT_EN undefined: wrap-around result as above.

Test Plan:
1. WIDTH=16, ADD a=0x0020 b=0x0020 -> next cycle result=0x00000040, done=1 for one cycle, ovf=0, busy never 1.
2. ADD 0x7FFF+0x0001 -> result=0xFFFF8000, ovf=1. With ALU_SAT_EN, result=0x00007FFF, ovf=1. Then SUB 0x0020-0x00AA -> result=0xFFFFFF76, ovf=0.
3. MUL 0x000A*0x000A -> busy=1 for 16 cycles, result=0x00000064 with done at accept+16. A start pulse mid-op is ignored. MUL 0xFFFF*0xFFFF -> 0xFFFE0001.
4. DIV 100/7 -> 0x0000000E. MOD 100/7 -> 0x00000002. DIV 5/0 -> result=0, dz=1, done one cycle after accept. Following ADD clears dz.
5. Chain: ADD 3+4 (result=7), then use_acc=1 MUL b=6 -> 0x0000002A, then use_acc=1 SHL b=0x0013 (shift 3) -> 0x00000150. CLR -> result=0, flags 0.
6. Reset mid-MUL (rst_n low at cycle 5 of 16) -> busy=0, done=0, result=0 immediately. After release a new ADD 1+1 -> 0x00000002.

Source files
------------

// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle arithmetic/logic ops, iterative shift-add multiply and
// restoring divide behind a start/busy/done handshake. Define ALU_SAT_EN to saturate ADD/SUB.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               use_acc,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               ovf,
    output logic               dz
);

    localparam int RW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_MOD  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_XNOR = 4'hC;
    localparam logic [3:0] OP_SHL  = 4'hD;
    localparam logic [3:0] OP_SHR  = 4'hE;
    localparam logic [3:0] OP_CLR  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              dz_q, dz_d;
    logic              done_q, done_d;
    logic              mod_q, mod_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [RW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  dvsr_q, dvsr_d;

    // Operand A comes from the result register when chaining.
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  add_b;
    logic              add_cin;
    logic              add_co;
    logic [WIDTH-1:0]  add_sum;
    logic              add_ovf;
    logic [WIDTH-1:0]  add_res;
    logic [SW-1:0]     shamt;
    logic [RW-1:0]     mul_acc_nx;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_trial;
    logic              div_ok;
    logic [WIDTH-1:0]  rem_nx;
    logic [WIDTH-1:0]  quo_nx;

    always_comb begin
        op_a    = use_acc ? result_q[WIDTH-1:0] : a;
        add_cin = (op == OP_SUB);
        add_b   = add_cin ? ~b : b;
        {add_co, add_sum} = {1'b0, op_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        // Carry into the MSB is recovered from the MSB sum bit.
        add_ovf = (op_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_sum[WIDTH-1]) ^ add_co;
`ifdef ALU_SAT_EN
        if (add_ovf)
            add_res = add_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        else
            add_res = add_sum;
`else
        add_res = add_sum;
`endif
        shamt = b[SW-1:0];

        mul_acc_nx = acc_q + (mplier_q[0] ? mcand_q : {RW{1'b0}});

        // Remainder stays below the divisor, so WIDTH+1 bits hold the trial difference.
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, dvsr_q};
        div_ok    = ~div_trial[WIDTH];
        rem_nx    = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_nx    = {quo_q[WIDTH-2:0], div_ok};
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        mod_d    = mod_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    ovf_d  = 1'b0;
                    dz_d   = 1'b0;
                    case (op)
                        OP_NOP: begin
                            ovf_d = ovf_q;
                            dz_d  = dz_q;
                        end
                        OP_ADD, OP_SUB: begin
                            result_d = {{WIDTH{add_res[WIDTH-1]}}, add_res};
                            ovf_d    = add_ovf;
                        end
                        OP_MUL: begin
                            done_d   = 1'b0;
                            acc_d    = {RW{1'b0}};
                            mcand_d  = {{WIDTH{1'b0}}, op_a};
                            mplier_d = b;
                            cnt_d    = {SW{1'b0}};
                            state_d  = ST_MUL;
                        end
                        OP_DIV, OP_MOD: begin
                            if (b == {WIDTH{1'b0}}) begin
                                result_d = {RW{1'b0}};
                                dz_d     = 1'b1;
                            end else begin
                                done_d  = 1'b0;
                                rem_d   = {WIDTH{1'b0}};
                                quo_d   = op_a;
                                dvsr_d  = b;
                                mod_d   = (op == OP_MOD);
                                cnt_d   = {SW{1'b0}};
                                state_d = ST_DIV;
                            end
                        end
                        OP_AND:  result_d = {{WIDTH{1'b0}}, op_a & b};
                        OP_OR:   result_d = {{WIDTH{1'b0}}, op_a | b};
                        OP_XOR:  result_d = {{WIDTH{1'b0}}, op_a ^ b};
                        OP_NOT:  result_d = {{WIDTH{1'b0}}, ~op_a};
                        OP_NAND: result_d = {{WIDTH{1'b0}}, ~(op_a & b)};
                        OP_NOR:  result_d = {{WIDTH{1'b0}}, ~(op_a | b)};
                        OP_XNOR: result_d = {{WIDTH{1'b0}}, ~(op_a ^ b)};
                        OP_SHL:  result_d = {{WIDTH{1'b0}}, op_a << shamt};
                        OP_SHR:  result_d = {{WIDTH{1'b0}}, op_a >> shamt};
                        OP_CLR:  result_d = {RW{1'b0}};
                        default: result_d = result_q;
                    endcase
                end
            end
            ST_MUL: begin
                acc_d    = mul_acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SW'(1);
                if (cnt_q == SW'(WIDTH - 1)) begin
                    result_d = mul_acc_nx;
                    ovf_d    = 1'b0;
                    dz_d     = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == SW'(WIDTH - 1)) begin
                    result_d = mod_q ? {{WIDTH{1'b0}}, rem_nx} : {{WIDTH{1'b0}}, quo_nx};
                    ovf_d    = 1'b0;
                    dz_d     = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= {RW{1'b0}};
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            mod_q    <= 1'b0;
            cnt_q    <= {SW{1'b0}};
            acc_q    <= {RW{1'b0}};
            mcand_q  <= {RW{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            rem_q    <= {WIDTH{1'b0}};
            quo_q    <= {WIDTH{1'b0}};
            dvsr_q   <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            mod_q    <= mod_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;
    assign dz     = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios then random ops, checked against an
// arithmetic reference model through an expected-result queue.
module tb_alu_seq;

    localparam int W  = 16;
    localparam int RW = 2 * W;
    localparam longint MAXP = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINN = -(longint'(1) <<< (W - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    op = 4'h0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          use_acc = 1'b0;
    logic          busy;
    logic          done;
    logic [RW-1:0] result;
    logic          ovf;
    logic          dz;

    int n_checks = 0;
    int n_errors = 0;
    logic [RW-1:0] exp_q[$];

    logic [RW-1:0] m_result = '0;
    logic          m_ovf = 1'b0;
    logic          m_dz = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .use_acc (use_acc),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .dz      (dz)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the effective operands.
    task automatic model_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, s;
        logic [W-1:0] rw;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o != 4'h0) begin
            m_ovf = 1'b0;
            m_dz  = 1'b0;
        end
        case (o)
            4'h0: ;
            4'h1, 4'h2: begin
                s = (o == 4'h1) ? sx + sy : sx - sy;
                m_ovf = (s > MAXP) || (s < MINN);
                rw = s[W-1:0];
`ifdef ALU_SAT_EN
                if (s > MAXP) rw = MAXP[W-1:0];
                if (s < MINN) rw = MINN[W-1:0];
`endif
                m_result = {{W{rw[W-1]}}, rw};
            end
            4'h3: begin
                s = longint'(x) * longint'(y);
                m_result = s[RW-1:0];
            end
            4'h4, 4'h5: begin
                if (y == '0) begin
                    m_result = '0;
                    m_dz = 1'b1;
                end else begin
                    m_result = {{W{1'b0}}, (o == 4'h4) ? x / y : x % y};
                end
            end
            4'h6: m_result = {{W{1'b0}}, x & y};
            4'h7: m_result = {{W{1'b0}}, x | y};
            4'h8: m_result = {{W{1'b0}}, x ^ y};
            4'h9: m_result = {{W{1'b0}}, ~x};
            4'hA: m_result = {{W{1'b0}}, ~(x & y)};
            4'hB: m_result = {{W{1'b0}}, ~(x | y)};
            4'hC: m_result = {{W{1'b0}}, ~(x ^ y)};
            4'hD: m_result = {{W{1'b0}}, x << (y % W)};
            4'hE: m_result = {{W{1'b0}}, x >> (y % W)};
            default: m_result = '0;
        endcase
    endtask

    // Driver: one op; poke raises a stray start while the op is busy.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit ua, input bit poke, input string tag);
        logic [W-1:0]  ax;
        logic [RW-1:0] e;
        bit multi;
        int cyc;
        @(negedge clk);
        op = o; a = x; b = y; use_acc = ua; start = 1'b1;
        ax = ua ? m_result[W-1:0] : x;
        multi = (o == 4'h3) || ((o == 4'h4 || o == 4'h5) && y != '0);
        model_op(o, ax, y);
        exp_q.push_back(m_result);
        @(posedge clk);
        #1;
        start = 1'b0; use_acc = 1'b0;
        if (!multi) begin
            check({tag, "_done"}, done, 1);
            check({tag, "_busy"}, busy, 0);
        end else begin
            check({tag, "_busy_start"}, busy, 1);
            check({tag, "_done_early"}, done, 0);
            cyc = 0;
            while (!done && cyc < 2 * W) begin
                if (poke && cyc == 4) begin
                    op = 4'h1; a = 16'h0001; b = 16'h0001; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            start = 1'b0;
            check({tag, "_latency"}, cyc, W);
            check({tag, "_busy_end"}, busy, 0);
        end
        e = exp_q.pop_front();
        check({tag, "_result"}, result, e);
        check({tag, "_ovf"}, ovf, m_ovf);
        check({tag, "_dz"}, dz, m_dz);
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        logic [3:0]   ro;
        logic [W-1:0] rx, ry;
        bit           rua;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_dz", dz, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'h1, 16'h0020, 16'h0020, 0, 0, "add_basic");
        check("add_basic_const", result, 32'h0000_0040);
        idle_check("add_basic");

        issue(4'h1, 16'h7FFF, 16'h0001, 0, 0, "add_ovf");
`ifdef ALU_SAT_EN
        check("add_ovf_const", result, 32'h0000_7FFF);
`else
        check("add_ovf_const", result, 32'hFFFF_8000);
`endif
        check("add_ovf_flag", ovf, 1);
        issue(4'h2, 16'h0020, 16'h00AA, 0, 0, "sub_neg");
        check("sub_neg_const", result, 32'hFFFF_FF76);

        issue(4'h3, 16'h000A, 16'h000A, 0, 1, "mul_small");
        check("mul_small_const", result, 32'h0000_0064);
        idle_check("mul_small");
        issue(4'h3, 16'hFFFF, 16'hFFFF, 0, 0, "mul_max");
        check("mul_max_const", result, 32'hFFFE_0001);

        issue(4'h4, 16'd100, 16'd7, 0, 0, "div");
        check("div_const", result, 32'h0000_000E);
        issue(4'h5, 16'd100, 16'd7, 0, 0, "mod");
        check("mod_const", result, 32'h0000_0002);
        issue(4'h4, 16'd5, 16'd0, 0, 0, "div_zero");
        check("div_zero_dz", dz, 1);
        issue(4'h1, 16'd1, 16'd1, 0, 0, "add_clr_dz");

        issue(4'h1, 16'd3, 16'd4, 0, 0, "chain_add");
        issue(4'h3, 16'h0000, 16'd6, 1, 0, "chain_mul");
        check("chain_mul_const", result, 32'h0000_002A);
        issue(4'hD, 16'h0000, 16'h0013, 1, 0, "chain_shl");
        check("chain_shl_const", result, 32'h0000_0150);
        issue(4'hF, 16'h1234, 16'h5678, 0, 0, "clr");
        check("clr_const", result, 0);

        // reset in the middle of a multiply
        @(negedge clk);
        op = 4'h3; a = 16'd3; b = 16'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        m_result = '0; m_ovf = 1'b0; m_dz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'h1, 16'd1, 16'd1, 0, 0, "post_rst_add");
        check("post_rst_add_const", result, 32'h0000_0002);

        // random ops against the model
        for (int i = 0; i < 80; i++) begin
            ro  = 4'($urandom_range(0, 15));
            rx  = W'($urandom);
            ry  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) ry = W'($urandom_range(0, 3));
            rua = 1'($urandom_range(0, 1));
            issue(ro, rx, ry, rua, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0h", i, ro));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
